// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, multi-cycle imem request handshake and the IF/ID
// pipeline register, with saturating freeze/redirect counters.
module if_fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hazard_detected,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic              if_id_valid,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt, req_addr, req_addr_nxt, pc_inc;
    logic              drop, drop_nxt;
    logic [31:0]       hold_instr, hold_nxt, acc_instr;
    logic              accept, freeze;

    assign pc_inc    = pc + ADDR_W'(4);
    assign freeze    = hazard_detected & ~branch_taken;
    assign imem_req  = (state == WAIT);
    assign imem_addr = req_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            drop       <= 1'b0;
            hold_instr <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            req_addr   <= req_addr_nxt;
            drop       <= drop_nxt;
            hold_instr <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        req_addr_nxt = req_addr;
        drop_nxt     = drop;
        hold_nxt     = hold_instr;
        accept       = 1'b0;
        acc_instr    = imem_rdata;
        case (state)
            IDLE: state_nxt = WAIT;
            WAIT: begin
                if (branch_taken) begin
                    pc_nxt = branch_target;
                    // A response still in flight must be swallowed when it lands.
                    if (imem_ready) begin
                        req_addr_nxt = branch_target;
                        drop_nxt     = 1'b0;
                    end else begin
                        drop_nxt     = 1'b1;
                    end
                end else if (imem_ready) begin
                    if (drop) begin
                        drop_nxt     = 1'b0;
                        req_addr_nxt = pc;
                    end else if (hazard_detected) begin
                        hold_nxt  = imem_rdata;
                        state_nxt = HOLD;
                    end else begin
                        accept = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_nxt       = branch_target;
                    req_addr_nxt = branch_target;
                    state_nxt    = WAIT;
                end else if (!hazard_detected) begin
                    accept    = 1'b1;
                    acc_instr = hold_instr;
                    state_nxt = WAIT;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (accept) begin
            pc_nxt       = pc_inc;
            req_addr_nxt = pc_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_id_instr <= '0;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
        end else if (accept) begin
            if_id_instr <= acc_instr;
            if_id_pc    <= pc_inc;
            if_id_valid <= 1'b1;
        end else if (!freeze) begin
            if_id_instr <= '0;
            if_id_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (freeze && stall_count != CNT_MAX)
                stall_count <= stall_count + 1'b1;
            if (branch_taken && flush_count != CNT_MAX)
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: transaction-level model plus directed scenarios,
// with a second instance using 2-bit counters to exercise saturation.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hazard_detected = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;

    logic        imem_req, if_id_valid;
    logic [31:0] imem_addr, if_id_instr, if_id_pc;
    logic [15:0] stall_count, flush_count;

    logic        d2_req, d2_valid;
    logic [31:0] d2_addr, d2_instr, d2_pc;
    logic [1:0]  d2_stall, d2_flush;

    int total = 0;
    int bad   = 0;
    int lat   = 0;
    int wcnt  = 0;

    if_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .hazard_detected(hazard_detected),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .if_id_valid(if_id_valid), .stall_count(stall_count), .flush_count(flush_count)
    );

    if_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .hazard_detected(hazard_detected),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(d2_req), .imem_addr(d2_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .if_id_instr(d2_instr), .if_id_pc(d2_pc),
        .if_id_valid(d2_valid), .stall_count(d2_stall), .flush_count(d2_flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Memory: answers each request after `lat` wait cycles; data = address.
    initial forever begin
        @(negedge clk);
        if (!rst || !imem_req) begin
            imem_ready = 1'b0;
            wcnt = 0;
        end else begin
            if (imem_ready) wcnt = 0;
            imem_ready = (wcnt >= lat);
            if (!imem_ready) wcnt++;
        end
        imem_rdata = imem_ready ? imem_addr : 32'hDEAD_BEEF;
    end

    // Model: next fetch address, a stale-response flag and a one-deep held queue.
    bit          m_started = 1'b0;
    bit          m_stale   = 1'b0;
    logic [31:0] m_pc = '0, m_req = '0;
    logic [31:0] m_held[$];
    logic [31:0] m_instr = '0, m_ipc = '0;
    bit          m_valid = 1'b0;
    int          m_stall = 0, m_flush = 0;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_started = 1'b0; m_stale = 1'b0; m_pc = '0; m_req = '0;
            m_held.delete(); m_instr = '0; m_ipc = '0; m_valid = 1'b0;
            m_stall = 0; m_flush = 0;
        end else begin
            bit          got;
            logic [31:0] word;
            got  = 1'b0;
            word = '0;
            if (hazard_detected && !branch_taken) m_stall++;
            if (branch_taken) m_flush++;
            if (!m_started) begin
                m_started = 1'b1;
            end else if (m_held.size() != 0) begin
                if (branch_taken) begin
                    m_held.delete();
                    m_pc  = branch_target;
                    m_req = branch_target;
                end else if (!hazard_detected) begin
                    word = m_held.pop_front();
                    got  = 1'b1;
                end
            end else if (branch_taken) begin
                m_pc = branch_target;
                if (imem_ready) begin
                    m_req   = branch_target;
                    m_stale = 1'b0;
                end else begin
                    m_stale = 1'b1;
                end
            end else if (imem_ready) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                    m_req   = m_pc;
                end else if (hazard_detected) begin
                    m_held.push_back(imem_rdata);
                end else begin
                    word = imem_rdata;
                    got  = 1'b1;
                end
            end
            if (got) begin
                m_pc    = m_pc + 32'd4;
                m_req   = m_pc;
                m_instr = word;
                m_ipc   = m_pc;
                m_valid = 1'b1;
            end else if (!(hazard_detected && !branch_taken)) begin
                m_instr = '0;
                m_valid = 1'b0;
            end
        end
    end

    initial forever begin
        bit exp_req;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_req = m_started && (m_held.size() == 0);
            chk("imem_req", imem_req, exp_req);
            if (exp_req) chk("imem_addr", imem_addr, m_req);
            chk("if_id_valid", if_id_valid, m_valid);
            chk("if_id_instr", if_id_instr, m_instr);
            chk("if_id_pc", if_id_pc, m_ipc);
            chk("stall_count", stall_count, sat(m_stall, 16));
            chk("flush_count", flush_count, sat(m_flush, 16));
            chk("d2_instr", d2_instr, m_instr);
            chk("d2_stall", d2_stall, sat(m_stall, 2));
            chk("d2_flush", d2_flush, sat(m_flush, 2));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!imem_ready && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (!imem_ready) begin
            bad++;
            $display("FAIL wait_ready: imem_ready still %b after %0d cycles", imem_ready, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", if_id_valid, 1'b0);
        chk("rst_instr", if_id_instr, 32'h0);
        chk("rst_pc", if_id_pc, 32'h0);
        chk("rst_stall", stall_count, 16'h0);
        chk("rst_flush", flush_count, 16'h0);
        rst = 1'b1;

        // zero-wait streaming
        tick();
        chk("idle_req", imem_req, 1'b1);
        chk("idle_addr", imem_addr, 32'h0);
        chk("idle_valid", if_id_valid, 1'b0);
        tick();
        chk("first_instr", if_id_instr, 32'h0);
        chk("first_pc", if_id_pc, 32'h4);
        chk("first_valid", if_id_valid, 1'b1);
        tick();
        chk("second_instr", if_id_instr, 32'h4);
        chk("second_pc", if_id_pc, 32'h8);
        repeat (3) tick();

        // three wait cycles per request
        lat = 3;
        repeat (10) tick();

        // freeze over a response for 4 cycles
        wait_ready();
        held = imem_rdata;
        hazard_detected = 1'b1;
        repeat (4) tick();
        chk("hold_req", imem_req, 1'b0);
        chk("hold_stall", stall_count, 16'd4);
        hazard_detected = 1'b0;
        tick();
        chk("hold_instr", if_id_instr, held);
        chk("hold_pc", if_id_pc, held + 32'd4);
        chk("hold_valid", if_id_valid, 1'b1);

        // redirect with a request outstanding
        branch_target = 32'h100;
        branch_taken  = 1'b1;
        tick();
        branch_taken = 1'b0;
        chk("br_flush", flush_count, 16'd1);
        chk("br_valid", if_id_valid, 1'b0);
        wait_ready();
        tick();
        chk("br_stale_addr", imem_addr, 32'h100);
        chk("br_stale_valid", if_id_valid, 1'b0);
        wait_ready();
        tick();
        chk("br_tgt_instr", if_id_instr, 32'h100);
        chk("br_tgt_pc", if_id_pc, 32'h104);

        // branch together with hazard while holding
        lat = 0;
        wait_ready();
        hazard_detected = 1'b1;
        tick();
        branch_target = 32'h200;
        branch_taken  = 1'b1;
        tick();
        branch_taken    = 1'b0;
        hazard_detected = 1'b0;
        chk("bh_stall", stall_count, 16'd5);
        chk("bh_flush", flush_count, 16'd2);
        chk("bh_req", imem_req, 1'b1);
        chk("bh_addr", imem_addr, 32'h200);
        chk("bh_valid", if_id_valid, 1'b0);

        // PC wrap at the top of the address space
        branch_target = 32'hFFFF_FFFC;
        branch_taken  = 1'b1;
        tick();
        branch_taken = 1'b0;
        tick();
        chk("wrap_instr", if_id_instr, 32'hFFFF_FFFC);
        chk("wrap_pc", if_id_pc, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // counter saturation on the 2-bit instance
        hazard_detected = 1'b1;
        repeat (6) tick();
        hazard_detected = 1'b0;
        chk("sat_stall16", stall_count, 16'd11);
        chk("sat_stall2", d2_stall, 2'd3);
        tick();
        tick();
        branch_target = 32'h40;
        branch_taken  = 1'b1;
        tick();
        branch_taken = 1'b0;
        chk("sat_flush16", flush_count, 16'd4);
        chk("sat_flush2", d2_flush, 2'd3);
        repeat (4) tick();

        // asynchronous reset in the middle of a wait
        lat = 3;
        tick();
        tick();
        @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_req", imem_req, 1'b0);
        chk("arst_valid", if_id_valid, 1'b0);
        chk("arst_instr", if_id_instr, 32'h0);
        chk("arst_stall", stall_count, 16'h0);
        chk("arst_flush", flush_count, 16'h0);
        tick();
        lat = 0;
        rst = 1'b1;
        tick();
        chk("arst_restart_addr", imem_addr, 32'h0);
        tick();
        chk("arst_restart_instr", if_id_instr, 32'h0);
        chk("arst_restart_valid", if_id_valid, 1'b1);
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
